// File: rtl/sm4_encryptor_pkg.sv
// Shared types for the SM4 request/response path: FSM states, mode encodings, block type.
// Latency: n/a. Backpressure: n/a.
package sm4_encryptor_pkg;

  localparam int BLK_W = 128;

  typedef logic [BLK_W-1:0] blk_t;

  typedef enum logic [1:0] {
    eIdle  = 2'd0,
    eIssue = 2'd1,
    eWait  = 2'd2,
    eOut   = 2'd3
  } state_e;

  localparam logic ENCODE_C = 1'b0;
  localparam logic DECODE_C = 1'b1;

  // Chaining XOR with an ECB bypass.
  function automatic blk_t cbc_xor(input blk_t a, input blk_t b, input logic bypass);
    return bypass ? a : (a ^ b);
  endfunction

endpackage

// File: rtl/sm4_cbc_requester.sv
// Host-side CBC wrapper around the sm4_encryptor v/ready request and v/yumi response channels.
// Latency: accept at T -> core_v_o at T+1; v_o one cycle after the core response. One block in flight.
// Backpressure: ready_o low while a block is in flight or flush_i is high; result held until yumi_i.
// Optional SM4_CBC_ECB_EN adds ecb_i to bypass chaining per block.
module sm4_cbc_requester
  import sm4_encryptor_pkg::*;
#(
  parameter int BLK_WIDTH_P = 128,
  parameter int CNT_WIDTH_P = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,

  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [BLK_WIDTH_P-1:0] data_i,
  input  logic [BLK_WIDTH_P-1:0] key_i,
  input  logic                   decrypt_i,
  input  logic                   first_i,
  input  logic [BLK_WIDTH_P-1:0] iv_i,
  input  logic                   flush_i,
`ifdef SM4_CBC_ECB_EN
  input  logic                   ecb_i,
`endif

  output logic                   v_o,
  output logic [BLK_WIDTH_P-1:0] data_o,
  input  logic                   yumi_i,
  output logic [CNT_WIDTH_P-1:0] blocks_o,

  output logic                   core_v_o,
  input  logic                   core_ready_i,
  output logic [BLK_WIDTH_P-1:0] core_content_o,
  output logic [BLK_WIDTH_P-1:0] core_key_o,
  output logic                   core_encode_or_decode_o,
  input  logic                   core_v_i,
  output logic                   core_yumi_o,
  input  logic [BLK_WIDTH_P-1:0] core_crypt_i,
  output logic                   core_invalid_cache_o
);

  if (BLK_WIDTH_P != 128) begin : g_bad_width
    $error("sm4_cbc_requester: BLK_WIDTH_P must be 128");
  end

  state_e                 state_r;
  logic                   ready_r;
  logic                   core_v_r;
  logic                   v_r;
  logic                   mode_r;
  logic [BLK_WIDTH_P-1:0] key_r;
  logic [BLK_WIDTH_P-1:0] data_r;
  logic [BLK_WIDTH_P-1:0] content_r;
  logic [BLK_WIDTH_P-1:0] chain_r;
  logic [BLK_WIDTH_P-1:0] out_r;
  logic [CNT_WIDTH_P-1:0] blocks_r;

  logic                   ecb_in;
  logic                   ecb_cur;
  logic [BLK_WIDTH_P-1:0] chain_use;
  logic                   accept;

`ifdef SM4_CBC_ECB_EN
  logic ecb_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ecb_r <= 1'b0;
    end else if (accept) begin
      ecb_r <= ecb_i;
    end
  end

  assign ecb_in  = ecb_i;
  assign ecb_cur = ecb_r;
`else
  assign ecb_in  = 1'b0;
  assign ecb_cur = 1'b0;
`endif

  // A new chain starts from iv_i; otherwise continue from the last ciphertext.
  assign chain_use = first_i ? iv_i : chain_r;
  assign accept    = (state_r == eIdle) && v_i && !flush_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= eIdle;
      ready_r   <= 1'b1;
      core_v_r  <= 1'b0;
      v_r       <= 1'b0;
      mode_r    <= ENCODE_C;
      key_r     <= '0;
      data_r    <= '0;
      content_r <= '0;
      chain_r   <= '0;
      out_r     <= '0;
      blocks_r  <= '0;
    end else begin
      case (state_r)
        eIdle: begin
          if (accept) begin
            key_r     <= key_i;
            mode_r    <= decrypt_i ? DECODE_C : ENCODE_C;
            data_r    <= data_i;
            content_r <= decrypt_i ? data_i : cbc_xor(data_i, chain_use, ecb_in);
            if (!ecb_in) begin
              chain_r <= chain_use;
            end
            ready_r   <= 1'b0;
            core_v_r  <= 1'b1;
            state_r   <= eIssue;
          end
        end
        eIssue: begin
          if (core_ready_i) begin
            core_v_r <= 1'b0;
            state_r  <= eWait;
          end
        end
        eWait: begin
          if (core_v_i) begin
            if (mode_r == ENCODE_C) begin
              out_r <= core_crypt_i;
              if (!ecb_cur) begin
                chain_r <= core_crypt_i;
              end
            end else begin
              // Decrypt chains on the received ciphertext, not on the core output.
              out_r <= cbc_xor(core_crypt_i, chain_r, ecb_cur);
              if (!ecb_cur) begin
                chain_r <= data_r;
              end
            end
            v_r     <= 1'b1;
            state_r <= eOut;
          end
        end
        eOut: begin
          if (yumi_i) begin
            v_r      <= 1'b0;
            ready_r  <= 1'b1;
            blocks_r <= blocks_r + 1'b1;
            state_r  <= eIdle;
          end
        end
        default: begin
          state_r  <= eIdle;
          ready_r  <= 1'b1;
          core_v_r <= 1'b0;
          v_r      <= 1'b0;
        end
      endcase
    end
  end

  // flush_i wins over a pending block and only takes effect while idle.
  assign ready_o                 = ready_r & ~flush_i;
  assign core_invalid_cache_o    = (state_r == eIdle) & flush_i;
  assign core_yumi_o             = (state_r == eWait) & core_v_i;

  assign v_o                     = v_r;
  assign data_o                  = out_r;
  assign blocks_o                = blocks_r;
  assign core_v_o                = core_v_r;
  assign core_content_o          = content_r;
  assign core_key_o              = key_r;
  assign core_encode_or_decode_o = mode_r;

endmodule

// File: tb/tb_sm4_cbc_requester.sv
// Scoreboard bench for sm4_cbc_requester with a behavioural core and a host-side result monitor.
module tb_sm4_cbc_requester;

  typedef struct {
    logic [127:0] content;
    logic [127:0] key;
    logic         mode;
  } req_t;

  localparam logic [127:0] P    = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C    = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] PXC  = 128'h693d9a535bad5bb1786f53d7253a7056;
  localparam logic [127:0] NC   = 128'h97e120cb2df969a1794c16b0ac91bdb9;
  localparam logic [127:0] D    = 128'h11112222333344445555666677778888;
  localparam logic [127:0] ND   = 128'heeeeddddccccbbbbaaaa999988887777;
  localparam logic [127:0] IV   = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
  localparam logic [127:0] DXIV = 128'h1e1e2d2d3c3c4b4b5a5a696978788787;
  localparam logic [127:0] NDXI = 128'he1e1d2d2c3c3b4b4a5a5969687877878;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         v_i, ready_o, decrypt_i, first_i, flush_i;
  logic [127:0] data_i, key_i, iv_i;
  logic         v_o, yumi_i;
  logic [127:0] data_o;
  logic [15:0]  blocks_o;
  logic         core_v_o, core_ready_i, core_encode_or_decode_o;
  logic [127:0] core_content_o, core_key_o, core_crypt_i;
  logic         core_v_i, core_yumi_o, core_invalid_cache_o;
`ifdef SM4_CBC_ECB_EN
  logic         ecb_i = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int exp_blocks = 0;
  int cs = 0;
  bit core_hold = 1'b0;
  bit hold_yumi = 1'b0;
  req_t         req_q[$];
  logic [127:0] out_q[$];

  always #5 clk_i = ~clk_i;

  sm4_cbc_requester dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .v_i(v_i), .ready_o(ready_o), .data_i(data_i), .key_i(key_i),
    .decrypt_i(decrypt_i), .first_i(first_i), .iv_i(iv_i), .flush_i(flush_i),
`ifdef SM4_CBC_ECB_EN
    .ecb_i(ecb_i),
`endif
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .blocks_o(blocks_o),
    .core_v_o(core_v_o), .core_ready_i(core_ready_i), .core_content_o(core_content_o),
    .core_key_o(core_key_o), .core_encode_or_decode_o(core_encode_or_decode_o),
    .core_v_i(core_v_i), .core_yumi_o(core_yumi_o), .core_crypt_i(core_crypt_i),
    .core_invalid_cache_o(core_invalid_cache_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Core stand-in: known SM4 vector pairs, otherwise a self-inverse toy cipher ~(x^k).
  function automatic logic [127:0] core_fn(input logic [127:0] x, input logic [127:0] k, input logic m);
    if (k == P && m == 1'b0 && x == P) return C;
    if (k == P && m == 1'b1 && x == C) return P;
    return ~(x ^ k);
  endfunction

  initial begin
    req_t r;
    logic [127:0] resp;
    core_v_i = 1'b0; core_ready_i = 1'b0; core_crypt_i = '0; resp = '0;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        cs = 0; core_v_i = 1'b0; core_ready_i = 1'b0;
      end else begin
        case (cs)
          0: if (core_v_o) begin
            if (req_q.size() == 0) bound_fail("core_req_unexpected");
            else begin
              r = req_q.pop_front();
              chk("core_content", core_content_o, r.content);
              chk("core_key", core_key_o, r.key);
              chk("core_mode", {127'd0, core_encode_or_decode_o}, {127'd0, r.mode});
            end
            resp = core_fn(core_content_o, core_key_o, core_encode_or_decode_o);
            core_ready_i = 1'b1;
            cs = 1;
          end
          1: begin core_ready_i = 1'b0; cs = 2; end
          2: if (!core_hold) begin
            core_v_i = 1'b1; core_crypt_i = resp; cs = 3;
            #1 chk("core_yumi", {127'd0, core_yumi_o}, 128'd1);
          end
          default: begin core_v_i = 1'b0; core_crypt_i = '0; cs = 0; end
        endcase
      end
    end
  end

  initial begin
    yumi_i = 1'b0;
    forever begin
      @(negedge clk_i);
      yumi_i = 1'b0;
      if (reset_n_i && v_o && !hold_yumi) begin
        if (out_q.size() == 0) bound_fail("data_o_unexpected");
        else chk("data_o", data_o, out_q.pop_front());
        yumi_i = 1'b1;
        exp_blocks++;
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [127:0] k, input logic dec,
                      input logic fst, input logic [127:0] iv, input logic [127:0] exp_content,
                      input logic [127:0] exp_out, input bit expect_out);
    int n;
    req_t r;
    r.content = exp_content; r.key = k; r.mode = dec;
    req_q.push_back(r);
    if (expect_out) out_q.push_back(exp_out);
    @(negedge clk_i);
    v_i = 1'b1; data_i = d; key_i = k; decrypt_i = dec; first_i = fst; iv_i = iv;
    n = 0;
    while (!ready_o && n < 100) begin @(negedge clk_i); n++; end
    if (!ready_o) bound_fail("accept");
    @(negedge clk_i);
    v_i = 1'b0; first_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((out_q.size() != 0 || v_o || cs != 0 || req_q.size() != 0) && n < 200) begin
      @(negedge clk_i); n++;
    end
    if (n >= 200) bound_fail("drain");
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    logic [127:0] rec;
    int n;
    reset_n_i = 1'b0; v_i = 1'b0; data_i = '0; key_i = '0; iv_i = '0;
    decrypt_i = 1'b0; first_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", {127'd0, ready_o}, 128'd1);
    chk("rst_v_o", {127'd0, v_o}, 128'd0);
    chk("rst_core_v", {127'd0, core_v_o}, 128'd0);
    chk("rst_blocks", {112'd0, blocks_o}, 128'd0);
    chk("rst_data_o", data_o, 128'd0);
    chk("rst_inval", {127'd0, core_invalid_cache_o}, 128'd0);
    reset_n_i = 1'b1;

    send(P, P, 1'b0, 1'b1, '0, P, C, 1);
    drain();
    send(C, P, 1'b1, 1'b1, '0, C, P, 1);
    drain();

    send(P, P, 1'b0, 1'b1, '0, P, C, 1);
    send(P, P, 1'b0, 1'b0, '0, PXC, NC, 1);
    drain();
    chk("blocks_after_cbc", {112'd0, blocks_o}, 128'(exp_blocks));
    chk("blocks_is_4", {112'd0, blocks_o}, 128'd4);

    send(C, P, 1'b1, 1'b1, '0, C, P, 1);
    send(NC, P, 1'b1, 1'b0, '0, NC, P, 1);
    drain();

    send(D, '0, 1'b0, 1'b1, IV, DXIV, NDXI, 1);
    drain();

    hold_yumi = 1'b1;
    send(C, P, 1'b1, 1'b1, '0, C, P, 1);
    n = 0;
    while (!v_o && n < 100) begin @(negedge clk_i); n++; end
    if (!v_o) bound_fail("hold_v_o");
    rec = data_o;
    chk("hold_data", rec, P);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk("hold_v_o", {127'd0, v_o}, 128'd1);
      chk("hold_data_stable", data_o, rec);
      chk("hold_ready", {127'd0, ready_o}, 128'd0);
      chk("hold_core_v", {127'd0, core_v_o}, 128'd0);
    end
    hold_yumi = 1'b0;
    drain();

    begin
      req_t r;
      r.content = P; r.key = P; r.mode = 1'b0;
      req_q.push_back(r);
      out_q.push_back(C);
    end
    @(negedge clk_i);
    v_i = 1'b1; data_i = P; key_i = P; decrypt_i = 1'b0; first_i = 1'b1; iv_i = '0; flush_i = 1'b1;
    #1;
    chk("flush_inval", {127'd0, core_invalid_cache_o}, 128'd1);
    chk("flush_ready", {127'd0, ready_o}, 128'd0);
    @(negedge clk_i);
    chk("flush_no_accept", {127'd0, core_v_o}, 128'd0);
    flush_i = 1'b0;
    #1;
    chk("flush_inval_drop", {127'd0, core_invalid_cache_o}, 128'd0);
    chk("flush_ready_back", {127'd0, ready_o}, 128'd1);
    @(negedge clk_i);
    v_i = 1'b0; first_i = 1'b0;
    drain();
    chk("blocks_before_reset", {112'd0, blocks_o}, 128'(exp_blocks));

    core_hold = 1'b1;
    send(P, P, 1'b0, 1'b1, '0, P, C, 0);
    n = 0;
    while (cs != 2 && n < 100) begin @(negedge clk_i); n++; end
    if (cs != 2) bound_fail("reach_wait");
    @(negedge clk_i);
    reset_n_i = 1'b0;
    #1;
    chk("midrst_v_o", {127'd0, v_o}, 128'd0);
    chk("midrst_core_v", {127'd0, core_v_o}, 128'd0);
    chk("midrst_ready", {127'd0, ready_o}, 128'd1);
    chk("midrst_blocks", {112'd0, blocks_o}, 128'd0);
    chk("midrst_core_yumi", {127'd0, core_yumi_o}, 128'd0);
    exp_blocks = 0;
    repeat (2) @(negedge clk_i);
    core_hold = 1'b0;
    reset_n_i = 1'b1;

    send(D, '0, 1'b0, 1'b0, '0, D, ND, 1);
    drain();
    chk("blocks_after_reset", {112'd0, blocks_o}, 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
